stack_seq: RTL and testbench

//  Bus-side driver for the 6502 stack. Owns S and turns push/pull requests of 1-3 bytes

---
 rtl/cpu_pkg.sv | 16 +
 rtl/sp_counter.sv | 40 ++++
 rtl/stack_seq.sv | 140 ++++++++++++++
 tb/tb_stack_seq.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU stack sequencer.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PUSH = 3'd1,
    ST_PULL = 3'd2,
    ST_WAIT = 3'd3,
    ST_DONE = 3'd4
  } stack_state_e;

  localparam logic [7:0] STACK_PAGE_DEFAULT = 8'h01;

  typedef logic [2:0][7:0] byte3_t;

endpackage

// File: rtl/sp_counter.sv
// 8-bit stack pointer register with load, increment, decrement and a wrap flag.
module sp_counter #(
  parameter logic [7:0] SP_RESET = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       inc,
  input  logic       dec,
  output logic [7:0] sp,
  output logic       wrap
);

  logic [7:0] sp_q;
  logic [7:0] sp_d;

  // wrap is flagged in the same cycle the crossing update is commanded
  always_comb begin
    sp_d = sp_q;
    wrap = 1'b0;
    if (load) begin
      sp_d = load_val;
    end else if (inc) begin
      sp_d = sp_q + 8'd1;
      wrap = (sp_q == 8'hFF);
    end else if (dec) begin
      sp_d = sp_q - 8'd1;
      wrap = (sp_q == 8'h00);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sp_q <= SP_RESET;
    else        sp_q <= sp_d;
  end

  assign sp = sp_q;

endmodule

// File: rtl/stack_seq.sv
// 6502 stack bus sequencer: turns 1-3 byte push/pull requests into byte cycles at STACK_PAGE:S.
//
// state | meaning
// IDLE  | ready for a request or a TXS load
// PUSH  | write strobe up for byte[cnt-1], waiting for grant
// PULL  | read strobe up at current S, waiting for grant
// WAIT  | capture read data returned one clock after grant
// DONE  | one-cycle completion pulse
module stack_seq
  import cpu_pkg::*;
#(
  parameter logic [7:0] STACK_PAGE = STACK_PAGE_DEFAULT,
  parameter logic [7:0] SP_RESET   = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sp_load,
  input  logic [7:0]  sp_in,
  output logic [7:0]  sp,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_pull,
  input  logic [1:0]  req_len,
  input  logic [23:0] req_data,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic        mem_re,
  output logic [7:0]  mem_wdata,
  input  logic        mem_gnt,
  input  logic [7:0]  mem_rdata,
  output logic [23:0] resp_data,
  output logic        done,
  output logic        sp_wrap
);

  stack_state_e state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [1:0]   idx_q, idx_d;
  byte3_t       buf_q, buf_d;
  byte3_t       resp_q, resp_d;
  logic         sp_ld, sp_inc, sp_dec;

  sp_counter #(.SP_RESET(SP_RESET)) u_sp (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (sp_ld),
    .load_val (sp_in),
    .inc      (sp_inc),
    .dec      (sp_dec),
    .sp       (sp),
    .wrap     (sp_wrap)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    buf_d     = buf_q;
    resp_d    = resp_q;
    sp_ld     = 1'b0;
    sp_inc    = 1'b0;
    sp_dec    = 1'b0;
    req_ready = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_wdata = 8'h00;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = ~sp_load;
        if (sp_load) begin
          sp_ld = 1'b1;
        end else if (req_valid) begin
          cnt_d  = req_len;
          idx_d  = 2'd0;
          buf_d  = req_data;
          resp_d = '0;
          if (req_len == 2'd0) begin
            state_d = ST_DONE;
          end else if (req_pull) begin
            // 6502 stack is empty-descending: pulls pre-increment S
            sp_inc  = 1'b1;
            state_d = ST_PULL;
          end else begin
            state_d = ST_PUSH;
          end
        end
      end
      ST_PUSH: begin
        mem_we    = 1'b1;
        mem_wdata = buf_q[cnt_q - 2'd1];
        if (mem_gnt) begin
          sp_dec = 1'b1;
          cnt_d  = cnt_q - 2'd1;
          if (cnt_q == 2'd1) state_d = ST_DONE;
        end
      end
      ST_PULL: begin
        mem_re = 1'b1;
        if (mem_gnt) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        resp_d[idx_q] = mem_rdata;
        idx_d         = idx_q + 2'd1;
        cnt_d         = cnt_q - 2'd1;
        if (cnt_q == 2'd1) begin
          state_d = ST_DONE;
        end else begin
          sp_inc  = 1'b1;
          state_d = ST_PULL;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
      idx_q   <= 2'd0;
      buf_q   <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      resp_q  <= resp_d;
    end
  end

  assign mem_addr  = {STACK_PAGE, sp};
  assign resp_data = resp_q;

endmodule

// File: tb/tb_stack_seq.sv
// Randomized self-checking bench for stack_seq against a byte-array stack model.
module tb_stack_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sp_load = 1'b0;
  logic [7:0]  sp_in = 8'h00;
  logic [7:0]  sp;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_pull = 1'b0;
  logic [1:0]  req_len = 2'd0;
  logic [23:0] req_data = 24'h0;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_wdata;
  logic        mem_gnt = 1'b0;
  logic [7:0]  mem_rdata = 8'h00;
  logic [23:0] resp_data;
  logic        done;
  logic        sp_wrap;

  int checks = 0;
  int errors = 0;
  logic [7:0] ref_mem [256];
  logic [7:0] bus_mem [256];
  logic [7:0] sp_model;

  stack_seq dut (
    .clk(clk), .rst_n(rst_n), .sp_load(sp_load), .sp_in(sp_in), .sp(sp),
    .req_valid(req_valid), .req_ready(req_ready), .req_pull(req_pull),
    .req_len(req_len), .req_data(req_data), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_re(mem_re), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rdata(mem_rdata), .resp_data(resp_data),
    .done(done), .sp_wrap(sp_wrap)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    @(negedge clk); #1;
    checks++; if (sp !== 8'h00) begin errors++; $display("FAIL reset_sp got %h exp 00", sp); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", req_ready); end
    checks++; if ({mem_we, mem_re, done, sp_wrap} !== 4'b0000) begin errors++; $display("FAIL reset_strobes got %b exp 0000", {mem_we, mem_re, done, sp_wrap}); end
    checks++; if ({mem_wdata, resp_data} !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", {mem_wdata, resp_data}); end
    @(negedge clk); rst_n = 1'b1;
    sp_model = 8'h00;
  endtask

  task automatic do_load(input logic [7:0] v);
    @(negedge clk); sp_load = 1'b1; sp_in = v;
    @(posedge clk); #1; sp_load = 1'b0; sp_in = $urandom;
    checks++; if (sp !== v) begin errors++; $display("FAIL load_sp got %h exp %h", sp, v); end
    sp_model = v;
  endtask

  // stall_mode: 0 = grant always, 1 = random grant, 2 = first three strobe cycles refused
  task automatic run_req(input logic pull, input logic [1:0] len, input logic [23:0] data,
                         input int stall_mode, input string name);
    logic [7:0]  exp_a[$];
    logic [7:0]  exp_w[$];
    logic [23:0] exp_resp;
    logic [7:0]  s, p_wd, p_sp, rd_lo;
    logic [15:0] p_addr;
    logic        p_we, p_re, g, strobe;
    int n, lat, cyc, wraps, exp_wraps, stalls, wi, ri, strobe_cyc;
    bit seen_done, prev_stall, rd_pend;
    n = int'(len);
    s = sp_model; exp_resp = '0; exp_wraps = 0;
    if (!pull) begin
      for (int i = n - 1; i >= 0; i--) begin
        exp_a.push_back(s); exp_w.push_back(data[8*i +: 8]);
        ref_mem[s] = data[8*i +: 8];
        if (s == 8'h00) exp_wraps++;
        s = s - 8'd1;
      end
    end else begin
      for (int i = 0; i < n; i++) begin
        if (s == 8'hFF) exp_wraps++;
        s = s + 8'd1;
        exp_a.push_back(s);
        exp_resp[8*i +: 8] = ref_mem[s];
      end
    end
    lat = (n == 0) ? 1 : (pull ? 2 * n + 1 : n + 1);
    cyc = 0; wraps = 0; stalls = 0; wi = 0; ri = 0; strobe_cyc = 0;
    seen_done = 0; prev_stall = 0; rd_pend = 0;
    p_addr = '0; p_we = 0; p_re = 0; p_wd = '0; p_sp = '0; rd_lo = '0;

    @(negedge clk);
    req_valid = 1'b1; req_pull = pull; req_len = len; req_data = data;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL %s accept_ready got %b exp 1", name, req_ready); end
    if (sp_wrap) wraps++;
    @(posedge clk); #1;
    req_valid = 1'b0; req_data = $urandom; req_len = 2'($urandom);

    while (cyc < 200 && !seen_done) begin
      @(negedge clk);
      cyc++;
      if (rd_pend) begin mem_rdata = bus_mem[rd_lo]; rd_pend = 0; end
      else mem_rdata = $urandom;
      if (done) begin
        seen_done = 1;
      end else begin
        if (prev_stall) begin
          checks++;
          if ({mem_addr, mem_we, mem_re, mem_wdata, sp} !== {p_addr, p_we, p_re, p_wd, p_sp}) begin
            errors++;
            $display("FAIL %s stall_hold got %h/%b%b/%h/%h exp %h/%b%b/%h/%h", name,
                     mem_addr, mem_we, mem_re, mem_wdata, sp, p_addr, p_we, p_re, p_wd, p_sp);
          end
        end
        strobe = mem_we | mem_re;
        g = 1'b1;
        if (strobe) begin
          strobe_cyc++;
          if (stall_mode == 1) g = ($urandom_range(0, 2) != 0);
          else if (stall_mode == 2) g = (strobe_cyc > 3);
          mem_gnt = g;
        end else begin
          mem_gnt = 1'($urandom);
        end
        #1;
        if (sp_wrap) wraps++;
        if (strobe && g) begin
          if (wi + ri >= n) begin
            checks++; errors++;
            $display("FAIL %s extra_cycle addr %h we %b re %b exp %0d cycles", name, mem_addr, mem_we, mem_re, n);
          end else if (mem_we) begin
            checks++;
            if ({mem_re, mem_addr, mem_wdata} !== {1'b0, 8'h01, exp_a[wi], exp_w[wi]}) begin
              errors++;
              $display("FAIL %s write%0d got re=%b %h=%h exp re=0 01%h=%h", name, wi, mem_re, mem_addr, mem_wdata, exp_a[wi], exp_w[wi]);
            end
            bus_mem[mem_addr[7:0]] = mem_wdata;
            wi++;
          end else begin
            checks++;
            if (mem_addr !== {8'h01, exp_a[ri]} || pull !== 1'b1) begin
              errors++;
              $display("FAIL %s read%0d got %h exp 01%h", name, ri, mem_addr, exp_a[ri]);
            end
            rd_lo = mem_addr[7:0]; rd_pend = 1; ri++;
          end
        end
        if (strobe && !g) stalls++;
        prev_stall = strobe && !g;
        p_addr = mem_addr; p_we = mem_we; p_re = mem_re; p_wd = mem_wdata; p_sp = sp;
      end
    end
    mem_gnt = 1'b0;

    checks++; if (!seen_done) begin errors++; $display("FAIL %s timeout got no done exp done within 200 cycles", name); end
    if (stall_mode != 1) begin
      checks++; if (cyc !== lat + stalls) begin errors++; $display("FAIL %s latency got %0d exp %0d", name, cyc, lat + stalls); end
    end
    checks++; if (wi + ri !== n) begin errors++; $display("FAIL %s byte_count got %0d exp %0d", name, wi + ri, n); end
    checks++; if (resp_data !== exp_resp) begin errors++; $display("FAIL %s resp_data got %h exp %h", name, resp_data, exp_resp); end
    checks++; if (sp !== s) begin errors++; $display("FAIL %s sp got %h exp %h", name, sp, s); end
    checks++; if (wraps !== exp_wraps) begin errors++; $display("FAIL %s sp_wrap got %0d exp %0d", name, wraps, exp_wraps); end
    @(negedge clk); #1;
    checks++; if ({done, req_ready} !== 2'b01) begin errors++; $display("FAIL %s after_done got done=%b ready=%b exp 0 1", name, done, req_ready); end
    sp_model = s;
  endtask

  task automatic test_push_pull();
    do_load(8'hFD);
    run_req(1'b0, 2'd3, 24'h123456, 0, "push3");
    run_req(1'b1, 2'd3, 24'h000000, 0, "pull3");
    checks++; if (resp_data !== 24'h123456) begin errors++; $display("FAIL pull3_const got %h exp 123456", resp_data); end
    run_req(1'b0, 2'd0, 24'hABCDEF, 0, "len0");
  endtask

  task automatic test_wrap();
    do_load(8'h00);
    run_req(1'b0, 2'd1, 24'h0000A5, 0, "push_wrap");
    run_req(1'b1, 2'd1, 24'h0, 0, "pull_wrap");
    checks++; if (resp_data[7:0] !== 8'hA5) begin errors++; $display("FAIL pull_wrap_byte got %h exp a5", resp_data[7:0]); end
    do_load(8'h01);
    run_req(1'b0, 2'd3, 24'hC0FFEE, 0, "push3_wrap");
    run_req(1'b1, 2'd2, 24'h0, 0, "pull2_wrap");
  endtask

  task automatic test_stall();
    do_load(8'h80);
    run_req(1'b0, 2'd3, 24'h5A6B7C, 2, "push_stall");
    run_req(1'b1, 2'd3, 24'h0, 2, "pull_stall");
  endtask

  task automatic test_load_vs_req();
    @(negedge clk);
    sp_load = 1'b1; sp_in = 8'h42;
    req_valid = 1'b1; req_pull = 1'b0; req_len = 2'd1; req_data = 24'h000099;
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL load_vs_req_ready got %b exp 0", req_ready); end
    @(posedge clk); #1;
    sp_load = 1'b0;
    checks++; if ({sp, mem_we, mem_re} !== {8'h42, 2'b00}) begin errors++; $display("FAIL load_vs_req_state got %h/%b%b exp 42/00", sp, mem_we, mem_re); end
    sp_model = 8'h42;
    run_req(1'b0, 2'd1, 24'h000099, 0, "req_after_load");
  endtask

  task automatic test_random();
    logic pull;
    logic [1:0] len;
    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 5) == 0) do_load(($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 2)) : 8'($urandom_range(253, 255)));
      pull = 1'($urandom);
      len  = 2'($urandom);
      run_req(pull, len, 24'($urandom), 1, pull ? "rand_pull" : "rand_push");
    end
  endtask

  task automatic test_reset_mid_pull();
    bit saw_done;
    @(negedge clk);
    req_valid = 1'b1; req_pull = 1'b1; req_len = 2'd3;
    @(posedge clk); #1;
    req_valid = 1'b0; mem_gnt = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if ({mem_we, mem_re, done} !== 3'b000) begin errors++; $display("FAIL rst_mid_strobes got %b exp 000", {mem_we, mem_re, done}); end
    checks++; if ({sp, req_ready, resp_data} !== {8'h00, 1'b1, 24'h0}) begin errors++; $display("FAIL rst_mid_state got %h/%b/%h exp 00/1/000000", sp, req_ready, resp_data); end
    @(negedge clk); rst_n = 1'b1; mem_gnt = 1'b0;
    saw_done = 0;
    repeat (6) begin @(negedge clk); if (done || mem_re || mem_we) saw_done = 1; end
    checks++; if (saw_done) begin errors++; $display("FAIL rst_mid_no_done got activity exp none"); end
    sp_model = 8'h00;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 8'($urandom);
      bus_mem[i] = ref_mem[i];
    end
    test_reset();
    do_load(8'hFD);
    test_push_pull();
    test_wrap();
    test_stall();
    test_load_vs_req();
    test_random();
    test_reset_mid_pull();
    run_req(1'b0, 2'd2, 24'h00BEEF, 0, "push_after_reset");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
